// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the round-robin decode arbiter.
package rr_arb_pkg;
    localparam int NUM_REQ      = 8;
    localparam int IDX_W        = 3;
    localparam int HOLD_W       = 8;
    localparam int HOLD_MAX_DEF = 15;

    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/grant_decoder.sv
// Combinational index-to-one-hot expansion with enable gate.
module grant_decoder
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/rr_decode_arbiter.sv
// 8-way round-robin arbiter with registered one-hot grant.
// Optional hold watchdog compiled in by defining RR_ARB_TIMEOUT_EN.
module rr_decode_arbiter
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld,
    output logic               timeout
);
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_d;
    logic               vld_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [IDX_W-1:0]   srch_idx;
    logic               rel;
    logic               expire;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        srch_idx = ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr_q + IDX_W'(i);
            if (req[cand]) srch_idx = cand;
        end
    end

    assign rel = done | ~req[gnt_idx];

`ifdef RR_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_q, hold_d;

    // Counter sits at zero in IDLE, so it starts from zero on entering GRANT.
    always_comb begin
        hold_d = '0;
        if (state_q == GRANT) hold_d = hold_q + HOLD_W'(1);
    end

    assign expire = (state_q == GRANT) && (hold_q == HOLD_W'(HOLD_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            timeout <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            timeout <= expire & ~rel;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = gnt_idx;
        vld_d   = gnt_vld;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    idx_d   = srch_idx;
                    vld_d   = 1'b1;
                end
            end
            GRANT: begin
                if (rel || expire) begin
                    state_d = IDLE;
                    ptr_d   = gnt_idx + IDX_W'(1);
                    idx_d   = '0;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    grant_decoder u_dec (
        .idx    (idx_d),
        .en     (vld_d),
        .onehot (gnt_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            gnt     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_idx <= idx_d;
            gnt_vld <= vld_d;
            gnt     <= gnt_d;
        end
    end
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed plus random bench for rr_decode_arbiter against a behavioural owner/pointer model.
module tb_rr_decode_arbiter;
    localparam int HM = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Model: current owner (-1 = none), rotating start point, cycles held so far.
    int m_owner, m_ptr, m_held;
    bit m_to;

    rr_decode_arbiter #(.HOLD_MAX(HM)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_held = 0; m_to = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] r, input logic d);
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int j = 0; j < 8; j++) begin
                if (m_owner < 0 && r[(m_ptr + j) % 8]) m_owner = (m_ptr + j) % 8;
            end
            m_held = (m_owner >= 0) ? 1 : 0;
        end else if (d || !r[m_owner]) begin
            m_ptr = (m_owner + 1) % 8; m_owner = -1; m_held = 0;
        end else if (TO_EN && m_held >= HM) begin
            m_ptr = (m_owner + 1) % 8; m_owner = -1; m_held = 0; m_to = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check(input string tag);
        logic [7:0] e_gnt;
        logic [2:0] e_idx;
        logic       e_vld;
        e_gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        e_idx = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        e_vld = (m_owner >= 0);
        total++;
        assert (gnt === e_gnt) else begin
            bad++; $error("FAIL %s gnt: got %h expected %h", tag, gnt, e_gnt);
        end
        total++;
        assert (gnt_idx === e_idx) else begin
            bad++; $error("FAIL %s gnt_idx: got %0d expected %0d", tag, gnt_idx, e_idx);
        end
        total++;
        assert (gnt_vld === e_vld) else begin
            bad++; $error("FAIL %s gnt_vld: got %b expected %b", tag, gnt_vld, e_vld);
        end
        total++;
        assert (timeout === m_to) else begin
            bad++; $error("FAIL %s timeout: got %b expected %b", tag, timeout, m_to);
        end
    endtask

    task automatic cycle(input logic [7:0] r, input logic d, input string tag);
        req = r; done = d;
        @(posedge clk);
        model_edge(r, d);
        #1 check(tag);
    endtask

    initial begin
        rst_n = 1'b0; req = 8'hFF; done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("reset");

        @(negedge clk) rst_n = 1'b1;
        cycle(8'hFF, 1'b0, "first_grant");
        total++;
        assert (gnt === 8'h01) else begin
            bad++; $error("FAIL first_grant_abs: got %h expected 01", gnt);
        end

        // Round robin: owner 0 releases, then 1..7 and back to 0.
        cycle(8'hFF, 1'b1, "rr_rel");
        for (int k = 0; k < 8; k++) begin
            cycle(8'hFF, 1'b0, "rr_grant");
            cycle(8'hFF, 1'b1, "rr_rel");
        end
        cycle(8'hFF, 1'b0, "rr_wrap");
        cycle(8'h00, 1'b0, "rr_drop");

        // Walk ptr to 6 via owner 5, then wrap/skip.
        cycle(8'h20, 1'b0, "to5");
        cycle(8'h20, 1'b1, "rel5");
        cycle(8'h05, 1'b0, "wrap0");
        total++;
        assert (gnt_idx === 3'd0) else begin
            bad++; $error("FAIL wrap0_abs: got %0d expected 0", gnt_idx);
        end
        cycle(8'h05, 1'b1, "rel0");
        cycle(8'h05, 1'b0, "skip2");
        cycle(8'h05, 1'b1, "rel2");

        // No preemption with owner 3.
        cycle(8'h08, 1'b0, "own3");
        for (int k = 0; k < 5; k++) cycle(8'hFF, 1'b0, "nopreempt");
        total++;
        assert (gnt === 8'h08) else begin
            bad++; $error("FAIL nopreempt_abs: got %h expected 08", gnt);
        end
        cycle(8'hFF, 1'b1, "rel3");
        cycle(8'h00, 1'b0, "idle");

        // done while idle is ignored.
        cycle(8'h00, 1'b1, "idle_done");

        // Long hold: watchdog fires if compiled in, otherwise grant persists.
        for (int k = 0; k < 100; k++) cycle(8'h10, 1'b0, "hold");
        cycle(8'h00, 1'b0, "hold_end");
        cycle(8'h00, 1'b0, "hold_idle");

        // done coinciding with expiry is an ordinary release.
        cycle(8'h10, 1'b0, "cx_g");
        for (int k = 1; k < HM; k++) cycle(8'h10, 1'b0, "cx_h");
        cycle(8'h10, 1'b1, "cx_rel");
        cycle(8'h00, 1'b0, "cx_idle");

        // Random traffic.
        for (int k = 0; k < 400; k++)
            cycle(8'($urandom), ($urandom_range(0, 3) == 0), "rand");

        // Mid-grant asynchronous reset.
        cycle(8'h00, 1'b0, "pre_rst");
        cycle(8'h20, 1'b0, "g5");
        cycle(8'h20, 1'b0, "g5_hold");
        #1 rst_n = 1'b0;
        model_reset();
        #1 check("async_rst");
        #2 rst_n = 1'b1;
        cycle(8'h20, 1'b0, "post_rst5");
        cycle(8'h20, 1'b1, "post_rel");
        cycle(8'h00, 1'b0, "post_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
